// File: rtl/dram_arbiter_if.sv
// Core-array and DRAM side signals of the shared data-memory arbiter.
// Packed per-core buses: core i occupies its own nibble or byte lane.
interface dram_arbiter_if #(
  parameter int NCORE = 4
);
  logic [4*NCORE-1:0] Mem_Ctrl_all;
  logic [8*NCORE-1:0] DAddress_all;
  logic [8*NCORE-1:0] Ddout_all;
  logic [NCORE-1:0]   acq;
  logic [7:0]         Ddin;
  logic [7:0]         mem_addr;
  logic [7:0]         mem_data;
  logic               mem_wren;
  logic [7:0]         mem_q;
  logic [NCORE-1:0]   gnt;
  logic               busy;

  modport slave (
    input  Mem_Ctrl_all, DAddress_all, Ddout_all, mem_q,
    output acq, Ddin, mem_addr, mem_data, mem_wren, gnt, busy
  );

  modport master (
    output Mem_Ctrl_all, DAddress_all, Ddout_all, mem_q,
    input  acq, Ddin, mem_addr, mem_data, mem_wren, gnt, busy
  );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter serialising per-core requests onto one DRAM port.
// Each transaction takes IDLE -> ACCESS -> RESP, one cycle each.
module dram_arbiter #(
  parameter int NCORE = 4
) (
  input  logic           CLK,
  input  logic           rst,
  dram_arbiter_if.slave  bus
);
  localparam int SW = $clog2(NCORE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [SW-1:0]    r_ptr;
  logic [SW-1:0]    r_sel;
  logic [7:0]       r_addr;
  logic [7:0]       r_data;
  logic             r_wren;
  logic [NCORE-1:0] w_req;
  logic [NCORE-1:0] w_wr;
  logic [SW-1:0]    w_win;
  logic             w_any;

  always_comb begin
    for (int i = 0; i < NCORE; i++) begin
      w_req[i] = bus.Mem_Ctrl_all[4*i] | bus.Mem_Ctrl_all[4*i+1];
      w_wr[i]  = bus.Mem_Ctrl_all[4*i+1];
    end
  end

  // Scan downward so the nearest requester above ptr wins last.
  always_comb begin
    logic [SW-1:0] v_idx;
    w_any = 1'b0;
    w_win = '0;
    for (int k = NCORE - 1; k >= 0; k--) begin
      v_idx = r_ptr + SW'(k);
      if (w_req[v_idx]) begin
        w_any = 1'b1;
        w_win = v_idx;
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_nstate = ACCESS;
      ACCESS:  w_nstate = RESP;
      RESP:    w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_sel  <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_wren <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel  <= w_win;
            r_addr <= bus.DAddress_all[int'(w_win)*8 +: 8];
            r_data <= bus.Ddout_all[int'(w_win)*8 +: 8];
            r_wren <= w_wr[w_win];
          end else begin
            r_wren <= 1'b0;
          end
        end
        ACCESS: r_wren <= 1'b0;
        RESP:   r_ptr  <= r_sel + 1'b1;
        default: r_wren <= 1'b0;
      endcase
    end
  end

  always_comb begin
    bus.Ddin     = bus.mem_q;
    bus.mem_addr = r_addr;
    bus.mem_data = r_data;
    bus.mem_wren = r_wren;
    bus.busy     = (r_state != IDLE);
    bus.gnt      = '0;
    bus.acq      = '0;
    for (int i = 0; i < NCORE; i++) begin
      bus.gnt[i] = (r_state != IDLE) && (r_sel == SW'(i));
      bus.acq[i] = ~w_req[i] |
                   ((r_state == RESP) && (r_sel == SW'(i)));
    end
  end
endmodule
